// File: rtl/systolic_pkg.sv
// Shared definitions for the weight-stationary systolic MAC chain.
//   - Default widths and sizes for the array.
//   - Controller state encoding: LOAD_W (serial weight load) and STREAM (activation stream).
//   - sat_shift(): arithmetic right shift followed by a signed clamp to an activation width.
package systolic_pkg;

  localparam int BN_NUM_D   = 8;
  localparam int ACCU_NUM_D = 4;
  localparam int BW_ACT_D   = 8;
  localparam int BW_WET_D   = 8;
  localparam int BW_ACCU_D  = 32;

  typedef enum logic {
    LOAD_W = 1'b0,
    STREAM = 1'b1
  } state_t;

  // The accumulator arrives sign-extended to 64 bits. A shift of the
  // accumulator width or more then naturally collapses to 0 or -1. The shift
  // floors (toward -inf), and the result is clamped to the signed range of
  // bw_act bits.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input logic        [7:0]  sh,
    input int                 bw_act
  );
    logic signed [63:0] s, hi, lo;
    s  = acc >>> sh;
    hi = (64'sd1 <<< (bw_act - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the weight-stationary MAC chain.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   i_clear       zero the partial sum; the weight is kept
//   i_load        capture i_wet into the stationary weight
//   i_step        advance: psum <= i_psum + act*weight
//   i_act         signed activation for this lane
//   i_wet         signed serial weight bus
//   i_psum        partial sum from the upstream PE (0 for the first)
//   o_psum        registered partial sum to the downstream PE
module systolic_pe #(
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int BW_ACCU = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [BW_ACT-1:0]  i_act,
  input  logic [BW_WET-1:0]  i_wet,
  input  logic [BW_ACCU-1:0] i_psum,
  output logic [BW_ACCU-1:0] o_psum
);

  logic        [BW_WET-1:0]         r_wet;
  logic        [BW_ACCU-1:0]        r_psum;
  logic signed [BW_ACT+BW_WET-1:0]  w_prod;

  // Full-precision signed product, sign-extended into the partial-sum width.
  assign w_prod = $signed(i_act) * $signed(r_wet);

  always_ff @(posedge clk) begin
    if (!reset_n)    r_wet <= '0;
    else if (i_load) r_wet <= i_wet;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)     r_psum <= '0;
    else if (i_clear) r_psum <= '0;
    else if (i_step)  r_psum <= i_psum + BW_ACCU'(w_prod);
  end

  assign o_psum = r_psum;

endmodule

// File: rtl/systolic_array_v1.sv
// Weight-stationary 1-D systolic MAC chain with per-row accumulators.
// ACCU_NUM weights are loaded serially. BN_NUM pre-skewed activation rows are
// then streamed, and each row's dot product is added into its own accumulator.
// Accumulators persist across tiles until a clear is issued.
// Ports:
//   clk, reset_n      clock and synchronous active-low reset
//   PE_mac_enable     advance enable; low freezes everything except clear
//   PE_clear_acc      zero accumulators/chain and restart at weight load
//   PE_act_in         ACCU_NUM skewed signed activation lanes
//   PE_wet_in         serial signed weight input
//   PE_res_shift_num  arithmetic right-shift applied to the results
//   PE_result_out     BN_NUM registered, shifted and saturated accumulators
module systolic_array_v1
  import systolic_pkg::*;
#(
  parameter int BN_NUM   = BN_NUM_D,
  parameter int ACCU_NUM = ACCU_NUM_D,
  parameter int BW_ACT   = BW_ACT_D,
  parameter int BW_WET   = BW_WET_D,
  parameter int BW_ACCU  = BW_ACCU_D
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             PE_mac_enable,
  input  logic                             PE_clear_acc,
  input  logic [ACCU_NUM-1:0][BW_ACT-1:0]  PE_act_in,
  input  logic [BW_WET-1:0]                PE_wet_in,
  input  logic [7:0]                       PE_res_shift_num,
  output logic [BN_NUM-1:0][BW_ACT-1:0]    PE_result_out
);

  localparam int STREAM_LEN = BN_NUM + ACCU_NUM;
  localparam int CW         = $clog2(STREAM_LEN);

  state_t                              r_state, w_state_nxt;
  logic [CW-1:0]                       r_cnt, w_cnt_nxt;
  logic [ACCU_NUM:0][BW_ACCU-1:0]      w_psum;
  logic [ACCU_NUM-1:0]                 w_load;
  logic [BN_NUM-1:0]                   w_acc_hit;
  logic                                w_step;
  logic [BN_NUM-1:0][BW_ACCU-1:0]      r_acc;
  logic [BN_NUM-1:0][BW_ACT-1:0]       r_result;

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (!reset_n || PE_clear_acc) begin
      r_state <= LOAD_W;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (PE_mac_enable) begin
      unique case (r_state)
        LOAD_W: begin
          if (r_cnt == CW'(ACCU_NUM - 1)) begin
            w_state_nxt = STREAM;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        STREAM: begin
          if (r_cnt == CW'(STREAM_LEN - 1)) begin
            w_state_nxt = LOAD_W;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = LOAD_W;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_step = PE_mac_enable && (r_state == STREAM);

  // ---------------- PE chain ----------------
  assign w_psum[0] = '0;

  for (genvar k = 0; k < ACCU_NUM; k++) begin : g_pe
    assign w_load[k] = PE_mac_enable && (r_state == LOAD_W) && (r_cnt == CW'(k));

    systolic_pe #(
      .BW_ACT  (BW_ACT),
      .BW_WET  (BW_WET),
      .BW_ACCU (BW_ACCU)
    ) u_pe (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clear (PE_clear_acc),
      .i_load  (w_load[k]),
      .i_step  (w_step),
      .i_act   (PE_act_in[k]),
      .i_wet   (PE_wet_in),
      .i_psum  (w_psum[k]),
      .o_psum  (w_psum[k+1])
    );
  end

  // The chain tail holds row r's dot product during stream cycle r+ACCU_NUM.
  // Rows are therefore retired at counter values ACCU_NUM..STREAM_LEN-1.
  for (genvar n = 0; n < BN_NUM; n++) begin : g_row
    assign w_acc_hit[n] = w_step && (r_cnt == CW'(n + ACCU_NUM));
  end

  // ---------------- accumulators + output ----------------
  // The output register samples the pre-update accumulator, so it lags by one
  // cycle. A clear zeroes it immediately.
  always_ff @(posedge clk) begin
    if (!reset_n || PE_clear_acc) begin
      r_acc    <= '0;
      r_result <= '0;
    end else if (PE_mac_enable) begin
      for (int n = 0; n < BN_NUM; n++) begin
        r_result[n] <= BW_ACT'(sat_shift($signed(r_acc[n]), PE_res_shift_num, BW_ACT));
        if (w_acc_hit[n]) r_acc[n] <= r_acc[n] + w_psum[ACCU_NUM];
      end
    end
  end

  assign PE_result_out = r_result;

endmodule

// File: tb/tb_systolic_array_v1.sv
module tb_systolic_array_v1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 en, clr;
  logic [3:0][7:0]      act;
  logic [7:0]           wet;
  logic [7:0]           shift;
  logic [7:0][7:0]      res;

  int checks = 0;
  int errors = 0;

  // Reference state: accumulated dot products per row, plus the current tile data.
  logic signed [31:0] m_acc [8];
  logic signed [7:0]  g_w   [4];
  logic signed [7:0]  g_a   [8][4];

  typedef struct {
    logic signed [7:0] w [4];
    int a_base;
    int a_step;
    int sh;
    int nt;
    int exp_o [8];
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  systolic_array_v1 dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .PE_mac_enable    (en),
    .PE_clear_acc     (clr),
    .PE_act_in        (act),
    .PE_wet_in        (wet),
    .PE_res_shift_num (shift),
    .PE_result_out    (res)
  );

  // floor(a / 2^sh), clamped to int8
  function automatic int ref_out(input logic signed [31:0] a, input int sh);
    longint v, d;
    if (sh >= 32) v = (a < 0) ? -1 : 0;
    else begin
      d = longint'(1) << sh;
      v = longint'(a) / d;
      if ((longint'(a) % d != 0) && a < 0) v = v - 1;
    end
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic check(input string name, input int idx, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", name, idx, got, expv);
    end
  endtask

  task automatic check_model(input string name);
    for (int n = 0; n < 8; n++)
      check(name, n, int'($signed(res[n])), ref_out(m_acc[n], int'(shift)));
  endtask

  task automatic step(input logic e, input logic c, input logic [7:0] w, input logic [3:0][7:0] a);
    en = e; clr = c; wet = w; act = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input string name);
    step(1'($urandom_range(0, 1)), 1'b1, 8'($urandom), 32'($urandom));
    for (int n = 0; n < 8; n++) m_acc[n] = 0;
    check_model(name);
  endtask

  // One tile: ACCU_NUM load cycles then BN_NUM+ACCU_NUM skewed stream cycles.
  // stall_at (0..15) inserts 3 disabled cycles before that overall cycle.
  // abort_at (stream index) asserts a clear in place of that stream cycle.
  task automatic run_tile(input bit chk_first, input int stall_at, input int abort_at);
    logic [3:0][7:0] a;
    int r;
    for (int j = 0; j < 16; j++) begin
      if (j == stall_at)
        repeat (3) step(1'b0, 1'b0, 8'($urandom), 32'($urandom));
      if (j < 4) begin
        step(1'b1, 1'b0, g_w[j], 32'($urandom));
        if (j == 0 && chk_first) check_model("tile_boundary");
      end else begin
        if (j - 4 == abort_at) begin
          do_clear("mid_clear");
          return;
        end
        for (int k = 0; k < 4; k++) begin
          r = (j - 4) - k;
          a[k] = (r >= 0 && r < 8) ? g_a[r][k] : 8'h00;
        end
        step(1'b1, 1'b0, 8'($urandom), a);
      end
    end
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 4; k++)
        m_acc[n] = m_acc[n] + 32'(int'(g_a[n][k]) * int'(g_w[k]));
  endtask

  task automatic flush();
    step(1'b1, 1'b0, 8'h00, '0);
  endtask

  task automatic load_vec(input int i);
    for (int k = 0; k < 4; k++) g_w[k] = tbl[i].w[k];
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 4; k++) g_a[n][k] = 8'(tbl[i].a_base + tbl[i].a_step * n);
    shift = 8'(tbl[i].sh);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{w:'{1, 2, 3, 4},         a_base:0,   a_step:1, sh:0,  nt:1, exp_o:'{0, 10, 20, 30, 40, 50, 60, 70}};
    tbl[1] = '{w:'{1, 1, 1, 1},         a_base:1,   a_step:0, sh:0,  nt:2, exp_o:'{8{8}}};
    tbl[2] = '{w:'{127, 127, 127, 127}, a_base:127, a_step:0, sh:0,  nt:1, exp_o:'{8{127}}};
    tbl[3] = '{w:'{-128, -128, -128, -128}, a_base:127, a_step:0, sh:0, nt:1, exp_o:'{8{-128}}};
    tbl[4] = '{w:'{127, 127, 127, 127}, a_base:127, a_step:0, sh:8,  nt:1, exp_o:'{8{127}}};
    tbl[5] = '{w:'{127, 127, 127, 127}, a_base:127, a_step:0, sh:10, nt:1, exp_o:'{8{63}}};
    tbl[6] = '{w:'{-128, -128, -128, -128}, a_base:127, a_step:0, sh:16, nt:1, exp_o:'{8{-1}}};
    tbl[7] = '{w:'{127, 127, 127, 127}, a_base:127, a_step:0, sh:40, nt:1, exp_o:'{8{0}}};
    tbl[8] = '{w:'{-128, -128, -128, -128}, a_base:127, a_step:0, sh:40, nt:1, exp_o:'{8{-1}}};
    tbl[9] = '{w:'{3, -1, 2, 1},        a_base:-4,  a_step:1, sh:1,  nt:1, exp_o:'{-10, -8, -5, -3, 0, 2, 5, 7}};

    for (int n = 0; n < 8; n++) m_acc[n] = 0;
    shift = 8'd0;

    // Reset has priority over an active enable.
    reset_n = 1'b0;
    step(1'b1, 1'b0, 8'($urandom), 32'($urandom));
    reset_n = 1'b1;
    check_model("reset");

    // Table-driven directed vectors.
    for (int i = 0; i < 10; i++) begin
      load_vec(i);
      for (int t = 0; t < tbl[i].nt; t++) run_tile(t > 0, -1, -1);
      flush();
      for (int n = 0; n < 8; n++) check($sformatf("vec%0d", i), n, int'($signed(res[n])), tbl[i].exp_o[n]);
      do_clear("clear_after_vec");
    end

    // Enable stall in the middle of the stream.
    load_vec(0);
    run_tile(1'b0, 10, -1);
    flush();
    for (int n = 0; n < 8; n++) check("stall", n, int'($signed(res[n])), tbl[0].exp_o[n]);
    do_clear("clear_after_stall");

    // Clear at stream cycle 5, then a full pass reproduces the single-tile result.
    run_tile(1'b0, -1, 5);
    run_tile(1'b0, -1, -1);
    flush();
    for (int n = 0; n < 8; n++) check("after_abort", n, int'($signed(res[n])), tbl[0].exp_o[n]);
    do_clear("clear_after_abort");

    // Reset mid-stream discards the partial pass.
    run_tile(1'b0, -1, 7);
    for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 8'($urandom), 32'($urandom));
    reset_n = 1'b0;
    step(1'b1, 1'b0, 8'($urandom), 32'($urandom));
    reset_n = 1'b1;
    check_model("mid_reset");

    // Randomized multi-tile runs against the reference model.
    for (int it = 0; it < 8; it++) begin
      int nt;
      shift = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 12));
      nt = $urandom_range(1, 3);
      for (int t = 0; t < nt; t++) begin
        for (int k = 0; k < 4; k++) g_w[k] = 8'($urandom);
        for (int n = 0; n < 8; n++)
          for (int k = 0; k < 4; k++) g_a[n][k] = 8'($urandom);
        run_tile(t > 0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1, -1);
      end
      flush();
      check_model("random");
      do_clear("clear_after_random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_array_v1.md
Name: systolic_array_v1

Overview:
- Weight-stationary 1-D systolic MAC chain of ACCU_NUM PEs.
- Computes, for BN_NUM activation rows, the dot product of each row's ACCU_NUM-wide slice with ACCU_NUM stationary weights.
- Adds each dot product into a per-row accumulator, which persists across passes so long inner dimensions are tiled.
- Outputs are shift-scaled, saturated BW_ACT results; the block sits between activation/weight buffers and output-activation memory.

Parameters:
- BN_NUM, 8, number of rows (output accumulators) per pass
- ACCU_NUM, 4, number of PEs (inner-dimension tile width)
- BW_ACT, 8, signed activation/result width
- BW_WET, 8, signed weight width
- BW_ACCU, 32, signed accumulator/partial-sum width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- PE_mac_enable  in  1  advance enable; 0 freezes all state except clear
- PE_clear_acc  in  1  zero accumulators/chain, restart at weight load
- PE_act_in[ACCU_NUM]  in  BW_ACT signed each  skewed activation lanes
- PE_wet_in  in  BW_WET signed  serial weight input
- PE_res_shift_num  in  8  arithmetic right-shift amount for results
- PE_result_out[BN_NUM]  out  BW_ACT signed each  scaled, saturated accumulators (registered)

Behaviour:
- Reset (reset_n=0 at posedge): all weights, chain psums, accumulators, PE_result_out = 0; FSM=LOAD_W, counter=0.
- Priority: reset > PE_clear_acc > PE_mac_enable=0 (hold) > normal step.
- PE_clear_acc=1 (with reset_n=1): accumulators and chain = 0, FSM=LOAD_W, counter=0. Weights are retained. Takes effect regardless of PE_mac_enable.
- FSM, advancing only when PE_mac_enable=1:
  - LOAD_W, ACCU_NUM cycles: in cycle c, weight[c] <= PE_wet_in. Then go to STREAM, counter=0.
  - STREAM, BN_NUM+ACCU_NUM cycles s=0..BN_NUM+ACCU_NUM-1. At s=last, go back to LOAD_W for the next tile; accumulators are kept.
- Lane input: caller pre-skews the lanes. In STREAM cycle s, PE_act_in[k] holds row (s-k) element k, or 0 when s-k is outside 0..BN_NUM-1.
- PE k, registered: psum[k] <= psum[k-1] + act[k]*weight[k], with psum[-1]=0. The product is a full BW_ACT+BW_WET signed value, sign-extended.
- Chain output: psum[ACCU_NUM-1] holds row r's dot product after STREAM cycle r+ACCU_NUM-1.
- Accumulate: in STREAM cycle s >= ACCU_NUM, acc[s-ACCU_NUM] <= acc[s-ACCU_NUM] + psum[ACCU_NUM-1].
- All sums wrap modulo 2^BW_ACCU.
- Chain psums are updated only in STREAM; they hold in LOAD_W.
- Output register, every cycle PE_mac_enable=1 or clear:
  - PE_result_out[n] <= sat(acc[n] >>> PE_res_shift_num). This is a one-cycle lag behind acc.
  - sat clamps to [-2^(BW_ACT-1), 2^(BW_ACT-1)-1].
  - Shift >= BW_ACCU gives 0 or -1 by sign.
  - Arithmetic shift truncates toward -infinity; no rounding.
- Results are final one cycle after the last STREAM cycle of the last tile.
- PE_mac_enable=0 mid-LOAD_W or mid-STREAM: exact pause; resuming continues identically.
- Reset or clear mid-operation discards the partial pass.

Decomposition:
- Package systolic_pkg: default widths, FSM state enum {LOAD_W, STREAM}, the saturating-shift function.
- Sub-module systolic_pe: weight register, multiplier, psum register. Instantiated ACCU_NUM times via generate.
- Top holds the FSM/counter, accumulators and output saturation.

Test Plan:
1. Reset: drive reset_n=0 one cycle -> all PE_result_out=0, FSM in LOAD_W.
2. Single tile, shift 0:
   - Weights 1,2,3,4; row r = {r,r,r,r}, skewed.
   - After LOAD_W(4)+STREAM(12)+1 cycles -> PE_result_out[r] = 10r, r=0..7, with saturation giving 70->70 (fits) and 10r for all.
3. Two tiles without clear:
   - Weights all 1, all activations 1 -> outputs 4 after tile 1, 8 after tile 2.
   - PE_clear_acc pulse -> next cycle outputs 0.
4. Saturation/shift:
   - Weights 127, activations 127 -> acc=64516; shift 0 -> 127.
   - Weights -128, activations 127 -> -128.
   - Shift 8 on acc=64516 -> 127 (252 saturates); shift 10 -> 63.
5. Enable stall: drop PE_mac_enable for 3 cycles mid-STREAM of scenario 2 -> identical final outputs, delayed by 3 cycles.
6. Clear mid-STREAM: assert PE_clear_acc at STREAM s=5 -> outputs 0 next cycle, FSM in LOAD_W, retained weights reloadable and a full pass reproduces scenario 2.
